// File: rtl/vliw_main_memory.sv
// ============================================================================
// Module   : vliw_main_memory
// Purpose  : Word-organised instruction/data memory for a VLIW core.
//            After reset the array is swept to zero (CLEAR), then a program
//            is loaded through the load port (LOAD), then the LSU read/write
//            port and the bundle fetch port run concurrently (RUN).
// Ports    : clk, rst (async, active-low)
//            ld_valid/ld_addr/ld_data/ld_done  - program load (LOAD only)
//            ready                             - high in RUN
//            wr_en/wr_addr/wr_data/wr_be       - LSU byte-masked write
//            rd_en/rd_addr/data_out/rd_valid   - LSU read, latency 1
//            lsu_err                           - misaligned / out-of-range LSU
//            fetch_en/pc_in                    - fetch request
//            inst_bundle_out/bundle_valid/fetch_err - fetch response, latency 1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vliw_main_memory #(
    parameter int DEPTH          = 256,
    parameter int SLOTS          = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    input  logic [31:0]           ld_addr,
    input  logic [31:0]           ld_data,
    input  logic                  ld_done,
    output logic                  ready,
    input  logic                  wr_en,
    input  logic [31:0]           wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_be,
    input  logic                  rd_en,
    input  logic [31:0]           rd_addr,
    output logic [31:0]           data_out,
    output logic                  rd_valid,
    output logic                  lsu_err,
    input  logic                  fetch_en,
    input  logic [31:0]           pc_in,
    output logic [32*SLOTS-1:0]   inst_bundle_out,
    output logic                  bundle_valid,
    output logic                  fetch_err
);

    localparam int c_AW = $clog2(DEPTH);

    localparam logic [1:0] c_ST_CLEAR = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_RESET = (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_LOAD;

    logic [1:0]      r_state;
    logic [c_AW-1:0] r_sweep;
    logic [31:0]     r_mem [DEPTH];

    // Word index is addr[31:2]; compared zero-extended so large addresses
    // never alias into the array.
    function automatic logic f_in_range(input logic [31:0] a);
        return (32'(a[31:2]) < 32'(DEPTH));
    endfunction

    logic w_run;
    logic w_rd_req;
    logic w_wr_req;
    logic w_fetch_req;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_wr_do;
    logic w_ld_do;
    logic w_clear_do;
    logic w_pc_misaligned;
    logic w_unused;

    assign w_run           = (r_state == c_ST_RUN);
    assign w_rd_req        = w_run && rd_en;
    assign w_wr_req        = w_run && wr_en;
    assign w_fetch_req     = w_run && fetch_en;
    assign w_rd_ok         = (rd_addr[1:0] == 2'b00) && f_in_range(rd_addr);
    assign w_wr_ok         = (wr_addr[1:0] == 2'b00) && f_in_range(wr_addr);
    assign w_wr_do         = w_wr_req && w_wr_ok;
    assign w_ld_do         = (r_state == c_ST_LOAD) && ld_valid && f_in_range(ld_addr);
    assign w_clear_do      = (r_state == c_ST_CLEAR);
    assign w_pc_misaligned = (pc_in[1:0] != 2'b00);
    // Load addresses are word-granular; the byte offset is don't-care.
    assign w_unused        = ^ld_addr[1:0];

    assign ready = w_run;

    // Fetch slots: slot 0 lands in the most significant word. The index sum
    // is carried in 32 bits so slots past the end read as NOP instead of
    // wrapping to the start of the array.
    logic [32*SLOTS-1:0] w_bundle;

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        logic [31:0] w_idx;
        assign w_idx = {2'b00, pc_in[31:2]} + 32'(k);
        assign w_bundle[32*(SLOTS-k)-1 -: 32] =
            (w_idx < 32'(DEPTH)) ? r_mem[w_idx[c_AW-1:0]] : 32'd0;
    end

    // Control FSM and sweep counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_RESET;
            r_sweep <= '0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    r_sweep <= r_sweep + 1'b1;
                    // DEPTH is a power of two, so the last index is all ones.
                    if (r_sweep == '1) begin
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    if (ld_done) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_state <= c_ST_RUN;
                end
                default: begin
                    r_state <= c_ST_RESET;
                end
            endcase
        end
    end

    // Registered response outputs. Reads sample the array before this
    // edge's write lands, giving read-before-write for LSU and fetch alike.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid        <= 1'b0;
            lsu_err         <= 1'b0;
            data_out        <= '0;
            bundle_valid    <= 1'b0;
            fetch_err       <= 1'b0;
            inst_bundle_out <= '0;
        end else begin
            rd_valid     <= w_rd_req;
            lsu_err      <= (w_rd_req && !w_rd_ok) || (w_wr_req && !w_wr_ok);
            bundle_valid <= w_fetch_req;
            fetch_err    <= w_fetch_req && w_pc_misaligned;
            if (w_rd_req) begin
                data_out <= w_rd_ok ? r_mem[rd_addr[c_AW+1:2]] : 32'd0;
            end
            if (w_fetch_req) begin
                inst_bundle_out <= w_pc_misaligned ? '0 : w_bundle;
            end
        end
    end

    // Storage array: no reset, only the CLEAR sweep zeroes it. The three
    // write sources are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (w_clear_do) begin
            r_mem[r_sweep] <= '0;
        end else if (w_ld_do) begin
            r_mem[ld_addr[c_AW+1:2]] <= ld_data;
        end else if (w_wr_do) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    r_mem[wr_addr[c_AW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vliw_main_memory.sv
// ============================================================================
// Module   : tb_vliw_main_memory
// Purpose  : Self-checking bench for vliw_main_memory (DEPTH=256, SLOTS=4).
//            Directed steps followed by randomized RUN traffic, checked
//            against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vliw_main_memory;

    localparam int DEPTH = 256;
    localparam int SLOTS = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 ld_valid = 1'b0;
    logic [31:0]          ld_addr = '0;
    logic [31:0]          ld_data = '0;
    logic                 ld_done = 1'b0;
    logic                 ready;
    logic                 wr_en = 1'b0;
    logic [31:0]          wr_addr = '0;
    logic [31:0]          wr_data = '0;
    logic [3:0]           wr_be = '0;
    logic                 rd_en = 1'b0;
    logic [31:0]          rd_addr = '0;
    logic [31:0]          data_out;
    logic                 rd_valid;
    logic                 lsu_err;
    logic                 fetch_en = 1'b0;
    logic [31:0]          pc_in = '0;
    logic [32*SLOTS-1:0]  inst_bundle_out;
    logic                 bundle_valid;
    logic                 fetch_err;

    vliw_main_memory #(
        .DEPTH          (DEPTH),
        .SLOTS          (SLOTS),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ld_valid        (ld_valid),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .ld_done         (ld_done),
        .ready           (ready),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_be           (wr_be),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .data_out        (data_out),
        .rd_valid        (rd_valid),
        .lsu_err         (lsu_err),
        .fetch_en        (fetch_en),
        .pc_in           (pc_in),
        .inst_bundle_out (inst_bundle_out),
        .bundle_valid    (bundle_valid),
        .fetch_err       (fetch_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0]         ref_mem [DEPTH];
    logic [31:0]         exp_data   = '0;
    logic [32*SLOTS-1:0] exp_bundle = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".ready"},        ready,           0);
        chk({tag, ".rd_valid"},     rd_valid,        0);
        chk({tag, ".lsu_err"},      lsu_err,         0);
        chk({tag, ".bundle_valid"}, bundle_valid,    0);
        chk({tag, ".fetch_err"},    fetch_err,       0);
        chk({tag, ".data_out"},     data_out,        0);
        chk({tag, ".bundle"},       inst_bundle_out, 0);
    endtask

    function automatic logic [31:0] ref_word(input longint idx);
        if (idx < DEPTH) return ref_mem[idx];
        return 32'd0;
    endfunction

    function automatic bit lsu_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr(input int max_idx);
        logic [31:0] a;
        a = 32'($urandom_range(0, max_idx)) * 4;
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        return a;
    endfunction

    // Sweep with ld_done held high: a correct sweep lasts DEPTH edges, so
    // ld_done is never seen in LOAD and ready must stay low throughout.
    task automatic sweep(input string tag);
        ld_done = 1'b1;
        rd_en = 1'b1; rd_addr = 32'h0;
        fetch_en = 1'b1; pc_in = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            chk({tag, ".ready"}, ready, 0);
        end
        ld_done = 1'b0; rd_en = 1'b0; fetch_en = 1'b0;
        chk({tag, ".rd_valid"}, rd_valid, 0);
        chk({tag, ".bundle_valid"}, bundle_valid, 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic done);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_done = done;
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_done = 1'b0;
        if ((a >> 2) < DEPTH) ref_mem[a >> 2] = d;
        chk("load.ready", ready, done);
    endtask

    task automatic run_cycle(input string tag,
                             input logic re, input logic [31:0] ra,
                             input logic we, input logic [31:0] wa,
                             input logic [31:0] wd, input logic [3:0] be,
                             input logic fe, input logic [31:0] pc);
        logic exp_err;
        logic exp_ferr;
        logic [32*SLOTS-1:0] eb;
        exp_err  = (re && lsu_bad(ra)) || (we && lsu_bad(wa));
        exp_ferr = fe && (pc[1:0] != 2'b00);
        if (re) exp_data = lsu_bad(ra) ? 32'd0 : ref_mem[ra >> 2];
        if (fe) begin
            eb = '0;
            if (pc[1:0] == 2'b00) begin
                for (int k = 0; k < SLOTS; k++)
                    eb = {eb[32*SLOTS-33:0], ref_word(longint'(pc >> 2) + k)};
            end
            exp_bundle = eb;
        end
        rd_en = re; rd_addr = ra;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        fetch_en = fe; pc_in = pc;
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; fetch_en = 1'b0;
        if (we && !lsu_bad(wa)) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[wa >> 2][8*b +: 8] = wd[8*b +: 8];
        end
        chk({tag, ".ready"},        ready,        1);
        chk({tag, ".rd_valid"},     rd_valid,     re);
        chk({tag, ".data_out"},     data_out,     exp_data);
        chk({tag, ".lsu_err"},      lsu_err,      exp_err);
        chk({tag, ".bundle_valid"}, bundle_valid, fe);
        chk({tag, ".fetch_err"},    fetch_err,    exp_ferr);
        if (fe) chk({tag, ".bundle"}, inst_bundle_out, exp_bundle);
    endtask

    initial begin
        // Reset state.
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Abort the sweep part-way through.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0; #1;
        check_zero("midclear");
        @(posedge clk); #1;
        rst = 1'b1;
        sweep("sweep1");

        // In LOAD: LSU/fetch ignored.
        rd_en = 1'b1; rd_addr = 32'h2; fetch_en = 1'b1; pc_in = 32'h1;
        wr_en = 1'b1; wr_addr = 32'h3; wr_be = 4'hF;
        @(posedge clk); #1;
        rd_en = 1'b0; fetch_en = 1'b0; wr_en = 1'b0;
        check_zero("load_ignore");

        // Partial load, then abort LOAD.
        load_word(32'h0, 32'hCAFEF00D, 1'b0);
        load_word(32'h4, 32'hBEEFBEEF, 1'b0);
        rst = 1'b0; #1;
        check_zero("midload");
        @(posedge clk); #1;
        rst = 1'b1;
        exp_data = '0;
        sweep("sweep2");

        // Program load.
        load_word(32'h0,   32'h11111111, 1'b0);
        load_word(32'h4,   32'h22222222, 1'b0);
        load_word(32'h8,   32'h33333333, 1'b0);
        load_word(32'hC,   32'h44444444, 1'b0);
        load_word(32'h40,  32'hAABBCCDD, 1'b0);
        load_word(32'h80,  32'h00000009, 1'b0);
        load_word(32'h3F8, 32'hDEAD0001, 1'b0);
        load_word(32'h3FC, 32'hDEAD0002, 1'b0);
        load_word(32'h400, 32'hFFFFFFFF, 1'b0);
        for (int i = 40; i < 60; i++) load_word(32'(i * 4), $urandom, 1'b0);
        load_word(32'h50, 32'h12345678, 1'b1);

        // Swept but unloaded word reads zero.
        run_cycle("zero_rd", 1, 32'h190, 0, 0, 0, 0, 0, 0);
        chk("zero_rd.lit", data_out, 32'h0);

        // Fetch from pc 0.
        run_cycle("fetch0", 0, 0, 0, 0, 0, 0, 1, 32'h0);
        chk("fetch0.lit", inst_bundle_out, 128'h11111111_22222222_33333333_44444444);

        // Byte-masked write then read; rd_valid only one cycle.
        run_cycle("be_wr", 0, 0, 1, 32'h40, 32'h00000011, 4'b0001, 0, 0);
        run_cycle("be_rd", 1, 32'h40, 0, 0, 0, 0, 0, 0);
        chk("be_rd.lit", data_out, 32'hAABBCC11);
        run_cycle("be_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Read-before-write on the same word, fetch sees pre-write too.
        run_cycle("rbw", 1, 32'h80, 1, 32'h80, 32'h5, 4'hF, 1, 32'h80);
        chk("rbw.lit", data_out, 32'h9);
        run_cycle("rbw_after", 1, 32'h80, 0, 0, 0, 0, 0, 0);
        chk("rbw_after.lit", data_out, 32'h5);

        // Erroneous LSU accesses.
        run_cycle("rd_mis", 1, 32'h402, 0, 0, 0, 0, 0, 0);
        run_cycle("rd_oor", 1, 32'h400, 0, 0, 0, 0, 0, 0);
        chk("rd_oor.lit", {lsu_err, rd_valid, data_out}, {2'b11, 32'h0});
        run_cycle("wr_oor", 0, 0, 1, 32'h400, 32'h77, 4'hF, 0, 0);
        run_cycle("wr_mis", 0, 0, 1, 32'h41, 32'h77, 4'hF, 0, 0);
        run_cycle("wr_be0", 0, 0, 1, 32'h44, 32'h77, 4'h0, 0, 0);
        run_cycle("chk_40", 1, 32'h40, 0, 0, 0, 0, 0, 0);

        // Fetch near the top of memory and misaligned fetch.
        run_cycle("fetch_top", 0, 0, 0, 0, 0, 0, 1, 32'h3F8);
        chk("fetch_top.lit", inst_bundle_out, 128'hDEAD0001_DEAD0002_00000000_00000000);
        run_cycle("fetch_mis", 0, 0, 0, 0, 0, 0, 1, 32'h2);

        // Load port ignored in RUN.
        ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'hFFFFFFFF;
        run_cycle("ld_in_run", 0, 0, 0, 0, 0, 0, 0, 0);
        ld_valid = 1'b0;
        run_cycle("ld_in_run_rd", 1, 32'h0, 0, 0, 0, 0, 0, 0);

        // Randomized concurrent traffic.
        for (int n = 0; n < 400; n++) begin
            run_cycle("rand",
                      1'($urandom_range(0, 1)), rand_addr(DEPTH + 3),
                      1'($urandom_range(0, 1)), rand_addr(DEPTH + 3),
                      $urandom, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), rand_addr(DEPTH + 1));
        end

        // Reset mid-RUN with outputs active.
        rd_en = 1'b1; rd_addr = 32'h4; fetch_en = 1'b1; pc_in = 32'h0;
        @(posedge clk); #1;
        chk("prerst.rd_valid", rd_valid, 1);
        rst = 1'b0; #1;
        rd_en = 1'b0; fetch_en = 1'b0;
        check_zero("midrun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vliw_main_memory.md
VLIW_MAIN_MEMORY -- requirements
Module: vliw_main_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256: memory size in 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter SLOTS, default 4: instructions per fetch bundle, 1..8.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero-sweep memory after reset; 0 = skip the sweep.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports ld_valid (in, 1), ld_addr (in, 32, byte address), ld_data (in, 32), ld_done (in, 1): program-load port.
REQ-007 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-008 SHALL have ports wr_en (in, 1), wr_addr (in, 32), wr_data (in, 32), wr_be (in, 4): LSU write, byte address, byte enables.
REQ-009 SHALL have ports rd_en (in, 1), rd_addr (in, 32), data_out (out, 32), rd_valid (out, 1): LSU read.
REQ-010 SHALL have port lsu_err, output, 1 bit: one-cycle pulse for an LSU access that is misaligned or out of range.
REQ-011 SHALL have ports fetch_en (in, 1), pc_in (in, 32): fetch request.
REQ-012 SHALL have ports inst_bundle_out (out, 32*SLOTS), bundle_valid (out, 1), fetch_err (out, 1): fetch response.

Function
REQ-013 SHALL implement the FSM CLEAR -> LOAD -> RUN; no other transitions exist except reset.
REQ-014 CLEAR SHALL write zero to one word per cycle, index 0..DEPTH-1, then enter LOAD; DEPTH cycles total.
REQ-015 When CLEAR_ON_RESET=0, the FSM SHALL enter LOAD on the first clock after reset deassertion.
REQ-016 In LOAD, ld_valid SHALL write ld_data to word ld_addr[31:2]; an out-of-range ld_addr is dropped silently.
REQ-017 In LOAD, ld_done SHALL move the FSM to RUN on the next edge; ld_valid and ld_done in the same cycle perform the write first, then transition.
REQ-018 ld_valid and ld_done SHALL be ignored outside LOAD; LSU and fetch requests SHALL be ignored outside RUN (no valid, no err).
REQ-019 Word index SHALL be addr[31:2]; the address is in range when addr[31:2] < DEPTH.
REQ-020 An LSU write in RUN SHALL update only the bytes with wr_be[i]=1, where byte i is bits [8i+7:8i]; wr_be=0 writes nothing and is not an error.
REQ-021 An LSU read SHALL have latency 1: rd_valid is high and data_out holds the word in the cycle after rd_en.
REQ-022 data_out SHALL hold its last value while rd_valid is low.
REQ-023 A read and a write to the same word in the same cycle SHALL return the pre-write data (read-before-write).
REQ-024 An LSU access with addr[1:0]!=0, or out of range, SHALL pulse lsu_err the next cycle; such a write is dropped.
REQ-025 Such an erroneous read SHALL still assert rd_valid, with data_out=0.
REQ-026 Fetch SHALL have latency 1: bundle_valid is high the cycle after fetch_en.
REQ-027 Slot k SHALL be the word at (pc_in>>2)+k, placed at bits [32*(SLOTS-k)-1 : 32*(SLOTS-k-1)], so slot 0 is most significant.
REQ-028 A fetch slot whose word index is >= DEPTH SHALL read 0 (NOP); the index does not wrap.
REQ-029 A fetch with pc_in[1:0]!=0 SHALL return an all-zero bundle with fetch_err=1 and bundle_valid=1.
REQ-030 Fetch SHALL see a same-cycle LSU write to a fetched word as pre-write data.
REQ-031 The fetch and LSU ports SHALL operate concurrently and independently every cycle.

Reset
REQ-032 rst low SHALL immediately force: state=CLEAR (or LOAD if CLEAR_ON_RESET=0), ready=0, rd_valid=0, lsu_err=0, bundle_valid=0, fetch_err=0, data_out=0, inst_bundle_out=0, sweep counter=0.
REQ-033 Memory contents SHALL NOT be reset asynchronously; only the CLEAR sweep zeroes them.
REQ-034 Reset asserted mid-CLEAR, mid-LOAD or mid-RUN SHALL abort the operation and restart from REQ-032; in-flight reads do not complete.

Verification
REQ-035 Reset, DEPTH=256, CLEAR_ON_RESET=1: ready stays 0 for 256 cycles, then LOAD; after ld_done, a read of any address returns 0.
REQ-036 In LOAD, write 0x11111111..0x44444444 to byte addresses 0x0..0xC, then ld_done; fetch pc_in=0 -> next cycle inst_bundle_out=0x11111111_22222222_33333333_44444444, bundle_valid=1.
REQ-037 Word 0x10 = 0xAABBCCDD; write wr_data=0x00000011 with wr_be=0001; then read -> data_out=0xAABBCC11, with rd_valid exactly one cycle after rd_en.
REQ-038 Same-cycle write 0x5 and read of word 0x20 (previously 0x9) -> data_out=0x9; a read the following cycle returns 0x5.
REQ-039 rd_addr=0x402 (misaligned), then rd_addr=0x400 with DEPTH=256 (out of range) -> each gives lsu_err=1, rd_valid=1, data_out=0; fetch pc_in=0x3F8, SLOTS=4 -> slots 2 and 3 are 0.
REQ-040 Assert rst mid-LOAD and mid-CLEAR sweep -> all outputs are 0 in the same cycle, and the sweep restarts at word 0 after release.
